// File: rtl/joy_db15_pkg.sv
// Shared definitions for the DB15 joystick serial link: default frame size,
// button bit positions and the two operating phases of the adapter model.
package joy_db15_pkg;

  localparam int BITS_PER_PLAYER_DEF = 12;

  localparam int JB_R  = 0;
  localparam int JB_L  = 1;
  localparam int JB_D  = 2;
  localparam int JB_U  = 3;
  localparam int JB_B1 = 4;
  localparam int JB_B2 = 5;
  localparam int JB_B3 = 6;
  localparam int JB_B4 = 7;
  localparam int JB_B5 = 8;
  localparam int JB_B6 = 9;
  localparam int JB_B7 = 10;
  localparam int JB_B8 = 11;

  typedef enum logic {
    PH_LOAD  = 1'b0,
    PH_SHIFT = 1'b1
  } phase_t;

  function automatic int frame_bits(input int bits_per_player);
    return 2 * bits_per_player;
  endfunction

endpackage

// File: rtl/joy_db15_tx_if.sv
// Pin-level bundle between the DB15 receiver (master) and the adapter model (slave).
interface joy_db15_tx_if
  import joy_db15_pkg::*;
#(
  parameter int BITS_PER_PLAYER = BITS_PER_PLAYER_DEF
);
  localparam int IDXW = $clog2(frame_bits(BITS_PER_PLAYER) + 1);

  logic            joy_clk_i;
  logic            joy_load_i;
  logic [15:0]     joystick1;
  logic [15:0]     joystick2;
  logic            joy_data_o;
  logic            frame_done;
  logic [IDXW-1:0] bit_index;
  logic            overrun;

  modport master (
    output joy_clk_i, joy_load_i, joystick1, joystick2,
    input  joy_data_o, frame_done, bit_index, overrun
  );

  modport slave (
    input  joy_clk_i, joy_load_i, joystick1, joystick2,
    output joy_data_o, frame_done, bit_index, overrun
  );
endinterface

// File: rtl/sync_filter.sv
// Two-flop synchronizer followed by a FILT-sample agreement filter; the output
// only follows the synchronized input once it has been stable for FILT samples.
module sync_filter #(
  parameter int   FILT    = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  localparam logic [2:0] RELOAD = 3'(FILT - 1);

  logic       s1, s2;
  logic [2:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1  <= RST_VAL;
      s2  <= RST_VAL;
      q   <= RST_VAL;
      cnt <= RELOAD;
    end else begin
      s1 <= d;
      s2 <= s1;
      // Down-counter restarts whenever the sample agrees with the output.
      if (s2 == q) begin
        cnt <= RELOAD;
      end else if (cnt == 3'd0) begin
        q   <= s2;
        cnt <= RELOAD;
      end else begin
        cnt <= cnt - 3'd1;
      end
    end
  end
endmodule

// File: rtl/joy_db15_tx.sv
// Device-side DB15 joystick adapter: parallel load of two players' buttons while
// JOY_LOAD is low, then one active-low bit per JOY_CLK rising edge on JOY_DATA.
module joy_db15_tx
  import joy_db15_pkg::*;
#(
  parameter int BITS_PER_PLAYER = BITS_PER_PLAYER_DEF,
  parameter int FILT            = 2
) (
  input logic          clk,
  input logic          reset,
  joy_db15_tx_if.slave bus
);
  // phase    | meaning
  // PH_LOAD  | load_f low: sr tracks inverted buttons, bit_index held at 0
  // PH_SHIFT | load_f high: shift on each clk_rise; bit_index==FRAME is DONE
  localparam int FRAME = frame_bits(BITS_PER_PLAYER);
  localparam int IDXW  = $clog2(FRAME + 1);

  logic             clk_f, load_f, clk_f_d, load_f_d;
  logic             clk_rise, load_fall;
  phase_t           phase;
  logic [FRAME-1:0] sr;
  logic [IDXW-1:0]  bit_index;
  logic             frame_done, overrun;

  sync_filter #(.FILT(FILT), .RST_VAL(1'b1)) u_clk_filt (
    .clk(clk), .reset(reset), .d(bus.joy_clk_i), .q(clk_f)
  );

  sync_filter #(.FILT(FILT), .RST_VAL(1'b1)) u_load_filt (
    .clk(clk), .reset(reset), .d(bus.joy_load_i), .q(load_f)
  );

  always_comb begin
    clk_rise  = clk_f & ~clk_f_d;
    load_fall = ~load_f & load_f_d;
    phase     = load_f ? PH_SHIFT : PH_LOAD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_f_d    <= 1'b1;
      load_f_d   <= 1'b1;
      sr         <= '1;
      bit_index  <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      clk_f_d    <= clk_f;
      load_f_d   <= load_f;
      frame_done <= 1'b0;
      if (phase == PH_LOAD) begin
        sr        <= ~{bus.joystick2[BITS_PER_PLAYER-1:0], bus.joystick1[BITS_PER_PLAYER-1:0]};
        bit_index <= '0;
      end else if (clk_rise) begin
        sr <= {1'b1, sr[FRAME-1:1]};
        if (bit_index != IDXW'(FRAME))
          bit_index <= bit_index + 1'b1;
        if (bit_index == IDXW'(FRAME - 1))
          frame_done <= 1'b1;
      end
      // A clock edge past the end of the frame latches until the next load.
      if (load_fall)
        overrun <= 1'b0;
      else if (phase == PH_SHIFT && clk_rise && bit_index == IDXW'(FRAME))
        overrun <= 1'b1;
    end
  end

  generate
    if (BITS_PER_PLAYER < 16) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^{bus.joystick1[15:BITS_PER_PLAYER], bus.joystick2[15:BITS_PER_PLAYER]};
    end
  endgenerate

  assign bus.joy_data_o = sr[0];
  assign bus.frame_done = frame_done;
  assign bus.bit_index  = bit_index;
  assign bus.overrun    = overrun;
endmodule

// File: tb/tb_joy_db15_tx.sv
// Bench for joy_db15_tx: acts as the DB15 receiver and checks the serial stream
// against a bit-list model built directly from the button words.
module tb_joy_db15_tx;
  localparam int B     = 12;
  localparam int FILT  = 2;
  localparam int FRAME = 2 * B;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   fd_total = 0;

  logic       cap_d  [0:FRAME];
  logic [4:0] cap_ix [0:FRAME];

  joy_db15_tx_if #(.BITS_PER_PLAYER(B)) bus ();

  joy_db15_tx #(.BITS_PER_PLAYER(B), .FILT(FILT)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (bus.frame_done === 1'b1) fd_total++;

  // Expected wire level of frame bit k: P1 bits, then P2 bits, then released.
  function automatic logic exp_bit(input logic [15:0] a, input logic [15:0] b, input int k);
    if (k < B) return ~a[k];
    else if (k < FRAME) return ~b[k - B];
    else return 1'b1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int lo, input int hi);
    bus.joy_clk_i = 1'b0;
    tick(lo);
    bus.joy_clk_i = 1'b1;
    tick(hi);
  endtask

  task automatic load_frame(input logic [15:0] a, input logic [15:0] b);
    bus.joystick1 = 16'($urandom);
    bus.joystick2 = 16'($urandom);
    bus.joy_load_i = 1'b0;
    tick(8);
    bus.joystick1 = a;
    bus.joystick2 = b;
    tick(12);
    bus.joy_load_i = 1'b1;
    tick(8);
  endtask

  task automatic capture_frame(input bit rnd);
    int lo, hi;
    for (int k = 0; k < FRAME; k++) begin
      cap_d[k]  = bus.joy_data_o;
      cap_ix[k] = bus.bit_index;
      lo = rnd ? int'($urandom_range(10, 3)) : 8;
      hi = rnd ? int'($urandom_range(10, 7)) : 8;
      pulse(lo, hi);
    end
    cap_d[FRAME]  = bus.joy_data_o;
    cap_ix[FRAME] = bus.bit_index;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.joy_clk_i  = 1'b1;
    bus.joy_load_i = 1'b1;
    bus.joystick1  = 16'h0;
    bus.joystick2  = 16'h0;
    tick(3);
    total += 4;
    if (bus.joy_data_o !== 1'b1) begin bad++; $display("FAIL rst_data: got %b want 1", bus.joy_data_o); end
    if (bus.bit_index !== 5'd0) begin bad++; $display("FAIL rst_idx: got %0d want 0", bus.bit_index); end
    if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL rst_fd: got %b want 0", bus.frame_done); end
    if (bus.overrun !== 1'b0) begin bad++; $display("FAIL rst_ovr: got %b want 0", bus.overrun); end
    reset = 1'b0;
    tick(12);
    total += 3;
    if (bus.joy_data_o !== 1'b1 || bus.bit_index !== 5'd0)
      begin bad++; $display("FAIL post_rst_state: got data=%b idx=%0d want 1/0", bus.joy_data_o, bus.bit_index); end
    if (fd_total !== 0) begin bad++; $display("FAIL post_rst_fd: got %0d pulses want 0", fd_total); end
    if (bus.overrun !== 1'b0) begin bad++; $display("FAIL post_rst_ovr: got %b want 0", bus.overrun); end
  endtask

  task automatic test_fixed_frame();
    int fd0 = fd_total;
    load_frame(16'h0005, 16'h0800);
    capture_frame(1'b0);
    for (int k = 0; k <= FRAME; k++) begin
      total += 2;
      if (cap_d[k] !== exp_bit(16'h0005, 16'h0800, k))
        begin bad++; $display("FAIL fixed_data[%0d]: got %b want %b", k, cap_d[k], exp_bit(16'h0005, 16'h0800, k)); end
      if (int'(cap_ix[k]) != k)
        begin bad++; $display("FAIL fixed_idx[%0d]: got %0d want %0d", k, cap_ix[k], k); end
    end
    total += 2;
    if (fd_total - fd0 != 1) begin bad++; $display("FAIL fixed_fd: got %0d pulses want 1", fd_total - fd0); end
    if (bus.overrun !== 1'b0) begin bad++; $display("FAIL fixed_ovr: got %b want 0", bus.overrun); end
  endtask

  // Runs straight after test_fixed_frame, while the adapter sits in DONE.
  task automatic test_overrun();
    int fd0 = fd_total;
    pulse(8, 8);
    pulse(8, 8);
    tick(20);
    total += 4;
    if (bus.joy_data_o !== 1'b1) begin bad++; $display("FAIL ovr_data: got %b want 1", bus.joy_data_o); end
    if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b want 1", bus.overrun); end
    if (bus.bit_index !== 5'(FRAME)) begin bad++; $display("FAIL ovr_idx: got %0d want %0d", bus.bit_index, FRAME); end
    if (fd_total != fd0) begin bad++; $display("FAIL ovr_fd: got %0d extra pulses want 0", fd_total - fd0); end
    bus.joy_load_i = 1'b0;
    tick(2 + FILT);
    total++;
    if (bus.overrun !== 1'b1) begin bad++; $display("FAIL ovr_early_clear: got %b want 1", bus.overrun); end
    tick(1);
    total += 2;
    if (bus.overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear: got %b want 0", bus.overrun); end
    if (bus.joy_data_o !== exp_bit(bus.joystick1, bus.joystick2, 0))
      begin bad++; $display("FAIL ovr_reload_data: got %b want %b", bus.joy_data_o, exp_bit(bus.joystick1, bus.joystick2, 0)); end
    tick(10);
    bus.joy_load_i = 1'b1;
    tick(8);
  endtask

  task automatic test_latency_glitch();
    load_frame(16'h0005, 16'h0000);
    bus.joy_clk_i = 1'b0;
    tick(8);
    bus.joy_clk_i = 1'b1;
    tick(2 + FILT);
    total++;
    if (bus.joy_data_o !== exp_bit(16'h0005, 16'h0, 0))
      begin bad++; $display("FAIL lat_early: got %b want %b", bus.joy_data_o, exp_bit(16'h0005, 16'h0, 0)); end
    tick(1);
    total += 2;
    if (bus.joy_data_o !== exp_bit(16'h0005, 16'h0, 1))
      begin bad++; $display("FAIL lat_exact: got %b want %b", bus.joy_data_o, exp_bit(16'h0005, 16'h0, 1)); end
    if (bus.bit_index !== 5'd1) begin bad++; $display("FAIL lat_idx: got %0d want 1", bus.bit_index); end
    tick(8);
    pulse(1, 12);
    total += 2;
    if (bus.bit_index !== 5'd1) begin bad++; $display("FAIL glitch_idx: got %0d want 1", bus.bit_index); end
    if (bus.joy_data_o !== exp_bit(16'h0005, 16'h0, 1))
      begin bad++; $display("FAIL glitch_data: got %b want %b", bus.joy_data_o, exp_bit(16'h0005, 16'h0, 1)); end
    pulse(2, 12);
    total += 2;
    if (bus.bit_index !== 5'd2) begin bad++; $display("FAIL pulse2_idx: got %0d want 2", bus.bit_index); end
    if (bus.joy_data_o !== exp_bit(16'h0005, 16'h0, 2))
      begin bad++; $display("FAIL pulse2_data: got %b want %b", bus.joy_data_o, exp_bit(16'h0005, 16'h0, 2)); end
  endtask

  task automatic test_abort();
    logic [15:0] a = 16'($urandom), b = 16'($urandom);
    logic [15:0] na = 16'($urandom) | 16'h0001, nb = 16'($urandom);
    int fd0;
    load_frame(a, b);
    fd0 = fd_total;
    for (int k = 0; k < 10; k++) pulse(6, 8);
    bus.joystick1 = na;
    bus.joystick2 = nb;
    bus.joy_load_i = 1'b0;
    tick(8);
    total += 3;
    if (bus.bit_index !== 5'd0) begin bad++; $display("FAIL abort_idx: got %0d want 0", bus.bit_index); end
    if (bus.joy_data_o !== ~na[0]) begin bad++; $display("FAIL abort_data: got %b want %b", bus.joy_data_o, ~na[0]); end
    if (fd_total != fd0) begin bad++; $display("FAIL abort_fd: got %0d pulses want 0", fd_total - fd0); end
    tick(12);
    bus.joy_load_i = 1'b1;
    tick(8);
    capture_frame(1'b1);
    for (int k = 0; k <= FRAME; k++) begin
      total++;
      if (cap_d[k] !== exp_bit(na, nb, k))
        begin bad++; $display("FAIL abort_rerun[%0d]: got %b want %b", k, cap_d[k], exp_bit(na, nb, k)); end
    end
    total++;
    if (fd_total - fd0 != 1) begin bad++; $display("FAIL abort_rerun_fd: got %0d pulses want 1", fd_total - fd0); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] a = 16'($urandom), b = 16'($urandom);
    load_frame(a, b);
    for (int k = 0; k < 7; k++) pulse(5, 8);
    total++;
    if (bus.bit_index !== 5'd7) begin bad++; $display("FAIL pre_rst_idx: got %0d want 7", bus.bit_index); end
    #3 reset = 1'b1;
    #1;
    total += 4;
    if (bus.joy_data_o !== 1'b1) begin bad++; $display("FAIL mid_rst_data: got %b want 1", bus.joy_data_o); end
    if (bus.bit_index !== 5'd0) begin bad++; $display("FAIL mid_rst_idx: got %0d want 0", bus.bit_index); end
    if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL mid_rst_fd: got %b want 0", bus.frame_done); end
    if (bus.overrun !== 1'b0) begin bad++; $display("FAIL mid_rst_ovr: got %b want 0", bus.overrun); end
    tick(2);
    reset = 1'b0;
    tick(4);
    a = 16'($urandom);
    b = 16'($urandom);
    load_frame(a, b);
    capture_frame(1'b1);
    for (int k = 0; k <= FRAME; k++) begin
      total++;
      if (cap_d[k] !== exp_bit(a, b, k))
        begin bad++; $display("FAIL post_rst_frame[%0d]: got %b want %b", k, cap_d[k], exp_bit(a, b, k)); end
    end
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 4; n++) begin
      logic [15:0] a = 16'($urandom), b = 16'($urandom);
      int extra = int'($urandom_range(3, 0));
      int fd0;
      load_frame(a, b);
      fd0 = fd_total;
      capture_frame(1'b1);
      for (int k = 0; k <= FRAME; k++) begin
        total += 2;
        if (cap_d[k] !== exp_bit(a, b, k))
          begin bad++; $display("FAIL rnd%0d_data[%0d]: got %b want %b", n, k, cap_d[k], exp_bit(a, b, k)); end
        if (int'(cap_ix[k]) != k)
          begin bad++; $display("FAIL rnd%0d_idx[%0d]: got %0d want %0d", n, k, cap_ix[k], k); end
      end
      for (int e = 0; e < extra; e++) pulse(4, 8);
      total += 3;
      if (fd_total - fd0 != 1) begin bad++; $display("FAIL rnd%0d_fd: got %0d pulses want 1", n, fd_total - fd0); end
      if (bus.overrun !== (extra > 0))
        begin bad++; $display("FAIL rnd%0d_ovr: got %b want %b", n, bus.overrun, extra > 0); end
      if (bus.joy_data_o !== 1'b1 || bus.bit_index !== 5'(FRAME))
        begin bad++; $display("FAIL rnd%0d_done: got data=%b idx=%0d want 1/%0d", n, bus.joy_data_o, bus.bit_index, FRAME); end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_frame();
    test_overrun();
    test_latency_glitch();
    test_abort();
    test_reset_mid();
    test_random_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/joy_db15_tx.md
Name: joy_db15_tx

Overview:
- Device-side end of the DB15 serial joystick link: a cycle-accurate model of the adapter's parallel-in/serial-out shift chain.
- Latches two players' button words when JOY_LOAD is low, then shifts one bit out per rising JOY_CLK edge on JOY_DATA.
- Used as a loopback/bench partner for the DB15 joystick receiver.
- Also used on a USER_IO pass-through build where the core acts as the adapter.

Parameters:
- BITS_PER_PLAYER, 12, button bits serialized per player.
- FILT, 2, consecutive equal samples required before a synchronized input is accepted (1..7).
- FRAME (localparam), 2*BITS_PER_PLAYER, total bits per frame.
- IDXW (localparam), $clog2(FRAME+1), width of bit_index.

Ports:
- clk  in  1  system clock, 40–50 MHz (same domain as CLK_JOY).
- reset  in  1  asynchronous, active-high.
- joy_clk_i  in  1  JOY_CLK from receiver, asynchronous.
- joy_load_i  in  1  JOY_LOAD from receiver, asynchronous, active-low load.
- joystick1  in  16  player 1 buttons, active-high pressed, codebase bit order (bit0=R, 1=L, 2=D, 3=U, 4+ buttons); bits [BITS_PER_PLAYER-1:0] used.
- joystick2  in  16  player 2, same format.
- joy_data_o  out  1  JOY_DATA, active-low (0 = pressed).
- frame_done  out  1  one-cycle pulse when the last frame bit has been shifted past.
- bit_index  out  IDXW  index of the bit currently presented, 0..FRAME.
- overrun  out  1  sticky: a JOY_CLK edge arrived after frame end.

Behaviour:
- Input conditioning, per input:
  - 2-flop synchronizer, then a FILT-deep filter.
  - The filtered value changes only after FILT consecutive synchronized samples equal the new value.
  - Pin-to-filtered latency: exactly 2+FILT cycles for a clean edge. Pulses shorter than FILT samples are ignored.
- Filter reset values: synchronizers and filtered values reset to 1 (idle high), so no edge is detected out of reset.
- Edge detection: clk_rise = clk_f & ~clk_f_d; load_fall = ~load_f & load_f_d; all registered.
- Shift register sr[FRAME-1:0], load phase (load_f==0):
  - Every cycle sr <= ~{joystick2[BITS-1:0], joystick1[BITS-1:0]}.
  - bit_index <= 0.
  - Load has priority over a coincident clk_rise.
- Shift phase (load_f==1), on clk_rise:
  - sr <= {1'b1, sr[FRAME-1:1]}, i.e. right shift with 1 fill.
  - bit_index <= bit_index+1, saturating at FRAME.
- Serial output: joy_data_o = sr[0], registered. Bit 0 is player1 bit0.
  - Wire order: P1 bit0..BITS-1, then P2 bit0..BITS-1.
  - After FRAME shifts, the output is constant 1 (all released).
- frame_done: asserted for exactly one cycle on the clk_rise that moves bit_index from FRAME-1 to FRAME.
- overrun:
  - Set on any clk_rise while bit_index==FRAME and load_f==1.
  - Cleared on load_fall.
  - If set and cleared in the same cycle, clear wins.
- Load mid-frame (load_fall with bit_index < FRAME): frame aborted, sr reloaded, no frame_done, overrun cleared.
- Held load: joystick changes during load are tracked every cycle. The value captured is the one present on the cycle before load_f rises.
- Pin-clock-edge to joy_data_o latency: 2+FILT+1 cycles (3+FILT from the register stage); the receiver must sample at least 5+FILT cycles after its clock edge.
- Reset (async, any time): sr all 1, joy_data_o=1, bit_index=0, frame_done=0, overrun=0. Operation resumes at the next load low.
- No state machine beyond two phases (LOAD, SHIFT) derived from load_f. bit_index==FRAME denotes DONE within SHIFT.

Decomposition:
- Shared package joy_db15_pkg:
  - Default BITS_PER_PLAYER.
  - Bit-position constants (JB_R=0, JB_L=1, JB_D=2, JB_U=3, JB_B1..JB_B8).
  - FRAME computation helper.
- Sub-module sync_filter: 2-flop synchronizer plus FILT-sample filter, with a parameterised reset value. Instantiated twice (clk, load).

Test Plan:
- Reset with pins idle high → joy_data_o=1, bit_index=0, frame_done=0, overrun=0; no edge detected after reset release.
- joystick1=16'h0005, joystick2=16'h0800; load low 20 cycles, high; 24 clean JOY_CLK pulses (8 cycles high/low) → serial stream 0,1,0,1,1,1,1,1,1,1,1,1, then 1×11, 0. frame_done pulses once after pulse 24, then bit_index=24.
- After a full frame, 2 extra JOY_CLK pulses → joy_data_o stays 1, overrun=1 and remains; next load low → overrun=0 within 2+FILT+1 cycles.
- 1-cycle glitch on joy_clk_i with FILT=2 → no shift, bit_index unchanged; 2-cycle pulse → exactly one shift.
- Load low after 10 shifts → bit_index=0, joy_data_o = ~P1 bit0, no frame_done; full rerun yields a correct frame.
- Assert reset at bit_index=7 → all outputs reset immediately (async), joy_data_o=1; following load/shift frame is correct.
